// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer: state encoding,
// default widths and the controller opcodes that decide fetch/load/store.
package mem_access_sequencer_pkg;

  localparam int DEF_AW     = 32;
  localparam int DEF_DW     = 32;
  localparam int DEF_TO_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // Opcodes the multicycle controller decodes; only loads/stores reach memory as data accesses.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_wait_counter.sv
// Timeout counter for an outstanding memory access; o_hit flags the cycle
// in which the LIMIT-th consecutive cycle without an acknowledge elapses.
module wait_counter #(
  parameter int CW    = 5,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  logic [CW-1:0] r_count;

  // Saturates at LIMIT so a stalled access can never wrap back into range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_hit = i_inc && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Makes a variable-latency unified memory look single-state to the multicycle
// controller. Optional access timeout is enabled with `define MEM_TIMEOUT_EN.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic          stall,
  output logic          misalign,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
`ifdef MEM_TIMEOUT_EN
  output logic          timeout,
`endif
  output state_t        dbg_state
);

  // Handshake: req is a command sampled only in IDLE (ignored in ACCESS/DONE);
  // mem_en and the mem_* fields stay constant until a one-cycle mem_ack, and
  // completion is reported to the controller by a one-cycle done pulse.

  if (TO_CYC < 1) begin : g_bad_to_cyc
    $error("TO_CYC must be at least 1");
  end

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  state_t        r_state;
  logic [DW-1:0] r_rdata;
  logic          r_done;
  logic          r_stall;
  logic          r_misalign;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          w_aligned;
  logic          w_accept;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n   = r_rst_sync[1];
  assign w_aligned = word_aligned(addr[1:0]);
  assign w_accept  = (r_state == ST_IDLE) && req && w_aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CW = $clog2(TO_CYC + 1);

  logic w_to_inc;
  logic w_to_hit;
  logic r_timeout;

  assign w_to_inc = (r_state == ST_ACCESS) && !mem_ack;

  wait_counter #(
    .CW   (TO_CW),
    .LIMIT(TO_CYC)
  ) u_wait_counter (
    .clk  (clk),
    .rst_n(w_rst_n),
    .i_clr(w_accept),
    .i_inc(w_to_inc),
    .o_hit(w_to_hit)
  );

  assign timeout = r_timeout;
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_rdata     <= '0;
      r_done      <= 1'b0;
      r_stall     <= 1'b0;
      r_misalign  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            if (w_aligned) begin
              r_mem_en    <= 1'b1;
              r_mem_we    <= we;
              r_mem_addr  <= {addr[AW-1:2], 2'b00};
              r_mem_wdata <= wdata;
              r_stall     <= 1'b1;
              r_state     <= ST_ACCESS;
            end else begin
              r_misalign <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_stall  <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_to_hit) begin
            // Give up on the memory: complete without touching rdata.
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_stall   <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign done      = r_done;
  assign stall     = r_stall;
  assign misalign  = r_misalign;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed scenarios plus randomized accesses
// against a cycle-count/queue model of the access protocol.
module tb_mem_access_sequencer;
  import mem_access_sequencer_pkg::*;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TO_CYC = 16;
  localparam int BOUND  = 60;

  typedef struct {
    int          first_en;
    int          en_cnt;
    int          stall_cnt;
    int          done_i;
    int          done_cnt;
    int          mis_i;
    int          mis_cnt;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        we0;
    bit          stable;
  } obs_t;

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          done;
  logic          stall;
  logic          misalign;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  state_t        dbg_state;
`ifdef MEM_TIMEOUT_EN
  logic          timeout;
`endif

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] model_rdata;
  logic [DW-1:0] exp_q[$];

  mem_access_sequencer #(.AW(AW), .DW(DW), .TO_CYC(TO_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .stall    (stall),
    .misalign (misalign),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
`ifdef MEM_TIMEOUT_EN
    .timeout  (timeout),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_cycles(input int n);
    req     = 1'b0;
    mem_ack = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issues one request (held for skip+1 cycles) and plays the memory, acking
  // in the lat-th mem_en cycle (lat=0: never). Returns at the done cycle.
  task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int lat, input logic [DW-1:0] md, input int skip,
                           output obs_t o);
    o.first_en = 0; o.en_cnt = 0; o.stall_cnt = 0; o.done_i = 0; o.done_cnt = 0;
    o.mis_i = 0; o.mis_cnt = 0; o.addr0 = '0; o.wdata0 = '0; o.we0 = 1'b0; o.stable = 1'b1;
    req = 1'b1; we = w; addr = a; wdata = wd; mem_ack = 1'b0;
    for (int i = 1; i <= BOUND; i++) begin
      @(negedge clk);
      if (i == skip + 1) req = 1'b0;
      if (mem_en === 1'b1) begin
        o.en_cnt++;
        if (o.first_en == 0) begin
          o.first_en = i; o.addr0 = mem_addr; o.wdata0 = mem_wdata; o.we0 = mem_we;
        end else if (mem_addr !== o.addr0 || mem_wdata !== o.wdata0 || mem_we !== o.we0) begin
          o.stable = 1'b0;
        end
      end
      if (stall === 1'b1) o.stall_cnt++;
      if (misalign === 1'b1) begin
        o.mis_cnt++;
        if (o.mis_i == 0) o.mis_i = i;
      end
      if (done === 1'b1) begin
        o.done_cnt++;
        if (o.done_i == 0) o.done_i = i;
      end
      mem_ack   = (mem_en === 1'b1) && (lat != 0) && (o.en_cnt == lat);
      mem_rdata = mem_ack ? md : DW'($urandom);
      if (o.done_i != 0) break;
      if (o.en_cnt == 0 && i >= skip + 3) break;
    end
    req     = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_en, mem_we, stall, done, misalign} !== 5'b0) begin
      n_errors++; $display("FAIL reset_strobes: got %b expected 00000", {mem_en, mem_we, stall, done, misalign});
    end
    n_checks++;
    if (rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_errors++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected 0", rdata, mem_addr, mem_wdata);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b1;
    idle_cycles(4);
    model_rdata = '0;
    n_checks++;
    if (stall !== 1'b0 || rdata !== model_rdata) begin
      n_errors++; $display("FAIL post_reset_idle: got stall=%b rdata=%h expected 0/0", stall, rdata);
    end
  endtask

  task automatic test_read();
    obs_t o;
    do_access(1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 0, o);
    model_rdata = 32'hDEAD_BEEF;
    n_checks++;
    if (o.first_en != 1 || o.en_cnt != 3 || o.stall_cnt != 3) begin
      n_errors++; $display("FAIL read_timing: got first_en=%0d en=%0d stall=%0d expected 1/3/3", o.first_en, o.en_cnt, o.stall_cnt);
    end
    n_checks++;
    if (o.done_i != 4 || o.done_cnt != 1) begin
      n_errors++; $display("FAIL read_done: got cycle=%0d count=%0d expected 4/1", o.done_i, o.done_cnt);
    end
    n_checks++;
    if (o.addr0 !== 32'h10 || o.we0 !== 1'b0 || !o.stable) begin
      n_errors++; $display("FAIL read_bus: got addr=%h we=%b stable=%0d expected 10/0/1", o.addr0, o.we0, o.stable);
    end
    n_checks++;
    if (rdata !== model_rdata) begin
      n_errors++; $display("FAIL read_rdata: got %h expected %h", rdata, model_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL read_done_pulse: got done=%b stall=%b expected 0/0", done, stall);
    end
  endtask

  task automatic test_store();
    obs_t o;
    do_access(1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hCAFE_F00D, 0, o);
    n_checks++;
    if (o.we0 !== 1'b1 || o.wdata0 !== 32'h1234_5678 || o.addr0 !== 32'h20 || !o.stable) begin
      n_errors++; $display("FAIL store_bus: got we=%b wdata=%h addr=%h expected 1/12345678/20", o.we0, o.wdata0, o.addr0);
    end
    n_checks++;
    if (o.done_i != 2 || o.en_cnt != 1) begin
      n_errors++; $display("FAIL store_timing: got done=%0d en=%0d expected 2/1", o.done_i, o.en_cnt);
    end
    n_checks++;
    if (rdata !== model_rdata) begin
      n_errors++; $display("FAIL store_rdata_kept: got %h expected %h", rdata, model_rdata);
    end
    idle_cycles(1);
    n_checks++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0) begin
      n_errors++; $display("FAIL store_release: got en=%b we=%b expected 0/0", mem_en, mem_we);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    do_access(1'b0, 32'h0000_0013, 32'h0, 1, 32'h5555_5555, 0, o);
    n_checks++;
    if (o.mis_cnt != 1 || o.mis_i != 1) begin
      n_errors++; $display("FAIL misalign_pulse: got count=%0d cycle=%0d expected 1/1", o.mis_cnt, o.mis_i);
    end
    n_checks++;
    if (o.en_cnt != 0 || o.stall_cnt != 0 || o.done_cnt != 0) begin
      n_errors++; $display("FAIL misalign_no_access: got en=%0d stall=%0d done=%0d expected 0/0/0", o.en_cnt, o.stall_cnt, o.done_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int   dones;
    req = 1'b1; we = 1'b0; addr = 32'h8; wdata = 32'h0; mem_ack = 1'b0;
    @(negedge clk);
    req = 1'b0;
    n_checks++;
    if (mem_en !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid_started: got mem_en=%b expected 1", mem_en);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_en, mem_we, stall, done, misalign} !== 5'b0 || rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_errors++; $display("FAIL rst_mid_outputs: got strobes=%b rdata=%h addr=%h expected all 0", {mem_en, mem_we, stall, done, misalign}, rdata, mem_addr);
    end
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || mem_en === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_errors++; $display("FAIL rst_mid_no_done: got %0d activity cycles expected 0", dones);
    end
    do_access(1'b0, 32'h4, 32'h0, 2, 32'h0BAD_F00D, 0, o);
    model_rdata = 32'h0BAD_F00D;
    n_checks++;
    if (o.done_i != 3 || o.addr0 !== 32'h4 || rdata !== model_rdata) begin
      n_errors++; $display("FAIL rst_mid_fresh_read: got done=%0d addr=%h rdata=%h expected 3/4/%h", o.done_i, o.addr0, rdata, model_rdata);
    end
    idle_cycles(1);
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdata !== model_rdata || done !== 1'b0 || mem_en !== 1'b0) begin
      n_errors++; $display("FAIL spurious_ack: got rdata=%h done=%b en=%b expected %h/0/0", rdata, done, mem_en, model_rdata);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    do_access(1'b0, 32'h0, 32'h0, 1, 32'h1111_2222, 0, o1);
    do_access(1'b0, 32'h4, 32'h0, 1, 32'h3333_4444, 1, o2);
    model_rdata = 32'h3333_4444;
    n_checks++;
    if (o1.done_i != 2 || o2.first_en != 2 || o2.done_i != 3 || o2.stall_cnt != 1) begin
      n_errors++; $display("FAIL b2b_timing: got d1=%0d en2=%0d d2=%0d st2=%0d expected 2/2/3/1", o1.done_i, o2.first_en, o2.done_i, o2.stall_cnt);
    end
    n_checks++;
    if (rdata !== model_rdata || o2.addr0 !== 32'h4) begin
      n_errors++; $display("FAIL b2b_data: got rdata=%h addr=%h expected %h/4", rdata, o2.addr0, model_rdata);
    end
    idle_cycles(1);
  endtask

  task automatic test_random();
    obs_t        o;
    bit          in_done;
    int          kind, lat, skip;
    logic [6:0]  op;
    logic [31:0] a, wd, md, exp_val;
    logic        w, aligned;
    in_done = 1'b0;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      op   = (kind < 3) ? OP_STORE : OP_LOAD;
      w    = (op == OP_STORE);
      a    = 32'($urandom_range(0, 1023)) * 4;
      if (kind == 9) a = a + 32'($urandom_range(1, 3));
      aligned = (a % 4 == 0);
      lat  = $urandom_range(1, 6);
      wd   = $urandom;
      md   = $urandom;
      skip = in_done ? 1 : 0;
      exp_val = (aligned && !w) ? md : model_rdata;
      model_rdata = exp_val;
      exp_q.push_back(exp_val);
      do_access(w, a, wd, lat, md, skip, o);
      if (aligned) begin
        n_checks++;
        if (o.first_en != skip + 1 || o.en_cnt != lat || o.stall_cnt != lat || o.done_i != skip + 1 + lat) begin
          n_errors++; $display("FAIL rand_timing[%0d]: got en@%0d n=%0d st=%0d done@%0d expected en@%0d n=%0d done@%0d", t, o.first_en, o.en_cnt, o.stall_cnt, o.done_i, skip + 1, lat, skip + 1 + lat);
        end
        n_checks++;
        if (o.addr0 !== (a & 32'hFFFF_FFFC) || o.we0 !== w || (w && o.wdata0 !== wd) || !o.stable || o.mis_cnt != 0) begin
          n_errors++; $display("FAIL rand_bus[%0d]: got addr=%h we=%b wdata=%h expected %h/%b/%h", t, o.addr0, o.we0, o.wdata0, a & 32'hFFFF_FFFC, w, wd);
        end
      end else begin
        n_checks++;
        if (o.mis_cnt != 1 || o.mis_i != skip + 1 || o.en_cnt != 0 || o.done_cnt != 0 || o.stall_cnt != 0) begin
          n_errors++; $display("FAIL rand_misalign[%0d]: got mis=%0d@%0d en=%0d done=%0d expected 1@%0d/0/0", t, o.mis_cnt, o.mis_i, o.en_cnt, o.done_cnt, skip + 1);
        end
      end
      exp_val = exp_q.pop_front();
      n_checks++;
      if (rdata !== exp_val) begin
        n_errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", t, rdata, exp_val);
      end
      if (aligned && $urandom_range(0, 1) == 1) begin
        in_done = 1'b1;
      end else begin
        in_done = 1'b0;
        idle_cycles(aligned ? $urandom_range(1, 3) : $urandom_range(0, 2));
      end
    end
    if (in_done) idle_cycles(1);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    n_checks++;
    if (timeout !== 1'b0) begin
      n_errors++; $display("FAIL timeout_initial: got %b expected 0", timeout);
    end
    do_access(1'b0, 32'h40, 32'h0, 0, 32'h7777_7777, 0, o);
    n_checks++;
    if (o.en_cnt != TO_CYC || o.done_i != TO_CYC + 1 || timeout !== 1'b1 || rdata !== model_rdata) begin
      n_errors++; $display("FAIL timeout_fire: got en=%0d done@%0d to=%b rdata=%h expected %0d/%0d/1/%h", o.en_cnt, o.done_i, timeout, rdata, TO_CYC, TO_CYC + 1, model_rdata);
    end
    idle_cycles(3);
    n_checks++;
    if (timeout !== 1'b1 || mem_en !== 1'b0) begin
      n_errors++; $display("FAIL timeout_sticky: got to=%b en=%b expected 1/0", timeout, mem_en);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (timeout !== 1'b0) begin
      n_errors++; $display("FAIL timeout_reset: got %b expected 0", timeout);
    end
    @(negedge clk);
    rst = 1'b1;
    model_rdata = '0;
    idle_cycles(4);
  endtask
`endif

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; model_rdata = '0;
    test_reset();
    test_read();
    test_store();
    test_misalign();
    test_reset_mid_access();
    test_spurious_ack();
    test_back_to_back();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Sits between the multicycle main controller/datapath and the unified instruction/data memory. The memory has variable latency, and this block makes it look like a memory that completes in one controller state.
- Captures a fetch, load or store request and holds the memory-side signals stable until the memory acknowledges.
- Returns read data in a register and raises `stall` so the controller freezes its state while the access is in flight.
- Flags misaligned word accesses without touching memory.

Parameters:
- `AW`, 32: address width in bits.
- `DW`, 32: data width in bits.
- `TO_CYC`, 16: timeout limit in cycles (used only with the optional feature).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low (`rst`==0 resets).
- `req`  in  1: access request from the controller; sampled in IDLE only.
- `we`  in  1: 1 = store (driven from `memWrite`), 0 = read.
- `addr`  in  AW: byte address (PC or ALU result, selected by `adrSrc` upstream).
- `wdata`  in  DW: store data.
- `rdata`  out  DW: registered read data; feeds IR/MDR.
- `done`  out  1: one-cycle pulse when the access completes.
- `stall`  out  1: high while an access is outstanding; controller holds `ps`.
- `misalign`  out  1: one-cycle pulse, request rejected because `addr[1:0]`!=0.
- `mem_en`  out  1: memory-side request strobe.
- `mem_we`  out  1: memory-side write enable.
- `mem_addr`  out  AW: memory-side word-aligned address.
- `mem_wdata`  out  DW: memory-side write data.
- `mem_rdata`  in  DW: memory-side read data; valid when `mem_ack`=1.
- `mem_ack`  in  1: memory completion, single-cycle pulse.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE.
  - All outputs 0; `rdata`=0, `mem_addr`=0, `mem_wdata`=0.
- States: IDLE, ACCESS, DONE. A 2-bit state register is sufficient.
- IDLE, `req`=1 and `addr[1:0]`==0:
  - Register `we`, `addr` (with `[1:0]` forced to 0) and `wdata` into the `mem_*` registers.
  - Next cycle: `mem_en`=1, `stall`=1, state=ACCESS.
- IDLE, `req`=1 and `addr[1:0]`!=0:
  - Next cycle `misalign`=1 for one cycle.
  - No memory access; stay IDLE; `stall` stays 0.
- IDLE, `req`=0: all strobes 0.
- ACCESS:
  - `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are held constant.
  - On `mem_ack`=1: if read, `rdata`<=`mem_rdata`; drop `mem_en`/`mem_we`; state=DONE.
  - `req` is ignored while in ACCESS.
- DONE (one cycle):
  - `done`=1 and `stall`=0.
  - `rdata` is valid and is held until the next completed read.
  - Next state is IDLE.
  - A `req` asserted in DONE is ignored. The controller re-requests in its next state, so back-to-back accesses have 1 idle cycle.
- Minimum latency: `req` in cycle N → `mem_en` in N+1 → `mem_ack` at earliest in N+1 → `done` in N+2.
- `mem_ack` in IDLE or DONE: ignored; `rdata` unchanged.
- Writes leave `rdata` unchanged.
- `stall` = (state==ACCESS) || (state==IDLE && `req` && aligned, registered). Concretely, `stall` is high from cycle N+1 through the `mem_ack` cycle.
- Reset mid-ACCESS: abort immediately; `mem_en` drops asynchronously and no `done` is generated.

Optional Feature:
- `MEM_TIMEOUT_EN` defined:
  - A counter of width clog2(`TO_CYC`+1) clears on entry to ACCESS and increments each ACCESS cycle without `mem_ack`.
  - When it reaches `TO_CYC`: drop `mem_en`, go to DONE with `done`=1, and set sticky output `timeout`=1 until reset.
  - `rdata` is unchanged on timeout.
  - Adds port `timeout` (out, 1).
- `MEM_TIMEOUT_EN` undefined:
  - No counter and no `timeout` port.
  - ACCESS waits indefinitely for `mem_ack`.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
  - Default widths `AW`/`DW`.
  - Opcode constants already used by the controller, for the bench.
- One natural sub-module: `wait_counter`, the timeout counter, instantiated only under `MEM_TIMEOUT_EN`.
- Everything else stays in this module.

Test Plan:
1. Read with `req`=1, `we`=0, `addr`=0x0000_0010, memory acks after 3 cycles with 0xDEAD_BEEF → `mem_en` held 3 cycles with `mem_addr`=0x10; `done` pulses once; `rdata`=0xDEAD_BEEF; `stall` high 3 cycles.
2. Store with `we`=1, `addr`=0x20, `wdata`=0x1234_5678, ack after 1 cycle → `mem_we`=1 and `mem_wdata` stable until ack; `rdata` keeps its previous value; `done` at N+2.
3. Misaligned read, `addr`=0x0000_0013 → `misalign` pulses 1 cycle; `mem_en` never asserts; `stall`=0; `done`=0.
4. Assert `rst`=0 during ACCESS (cycle 2 of 5) → all outputs 0 asynchronously; after release a fresh read to 0x4 completes normally.
5. Spurious `mem_ack` in IDLE with `mem_rdata`=0xFFFF_FFFF → `rdata` unchanged, `done`=0. Then back-to-back reads to 0x0 and 0x4 → two `done` pulses with 1 idle cycle between.
6. With `MEM_TIMEOUT_EN`, `TO_CYC`=16, no ack → `done` and `timeout` rise after 16 ACCESS cycles; `timeout` stays 1 until reset; `mem_en` drops.
